// File: rtl/wb_mux_n.sv
// wb_mux_n: Wishbone classic interconnect, one master to NUM_SLAVES slaves.
//   Address decode is registered into sel_idx when a request is accepted and
//   stays locked for the whole transfer. Decode misses and slave timeouts are
//   answered with a one-cycle interconnect error. The first such error is held
//   in a sticky capture register until err_clr_i.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   wbm_*                   master side (adr/dat/we/sel/stb/cyc in, dat/ack/err/rty out)
//   wbs_*_o / wbs_*_i       per-slave buses, slice i belongs to slave i
//   wbs_addr, wbs_addr_msk  per-slave address prefix and prefix mask
//   err_valid_o/addr_o/timeout_o, err_clr_i   error capture register

// Per-slave port: address match and gating of the master control lines.
module wb_mux_n_port #(
  parameter int AW = 32
) (
  input  logic [AW-1:0] adr,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] msk,
  input  logic          act,    // this slave owns the current transfer
  input  logic          cyc,
  input  logic          stb,
  input  logic          we,
  output logic          match,
  output logic          cyc_o,
  output logic          stb_o,
  output logic          we_o
);
  assign match = ~|((adr ^ base) & msk);
  assign cyc_o = act & cyc;
  assign stb_o = act & stb;
  assign we_o  = act & we;
endmodule

module wb_mux_n #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH/8,
  parameter int NUM_SLAVES   = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]            wbm_dat_i,
  output logic [DATA_WIDTH-1:0]            wbm_dat_o,
  input  logic                             wbm_we_i,
  input  logic [SELECT_WIDTH-1:0]          wbm_sel_i,
  input  logic                             wbm_stb_i,
  input  logic                             wbm_cyc_i,
  output logic                             wbm_ack_o,
  output logic                             wbm_err_o,
  output logic                             wbm_rty_o,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] wbs_adr_o,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
  output logic [NUM_SLAVES-1:0]            wbs_we_o,
  output logic [NUM_SLAVES*SELECT_WIDTH-1:0] wbs_sel_o,
  output logic [NUM_SLAVES-1:0]            wbs_stb_o,
  output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
  input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]            wbs_err_i,
  input  logic [NUM_SLAVES-1:0]            wbs_rty_i,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] wbs_addr,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] wbs_addr_msk,
  output logic                             err_valid_o,
  output logic [ADDR_WIDTH-1:0]            err_addr_o,
  output logic                             err_timeout_o,
  input  logic                             err_clr_i
);
  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // Counter only needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_ERR    = 2'd2;

  logic [1:0]            state, state_nx;
  logic [IW-1:0]         sel_idx, hit_idx;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] dec_adr;   // address seen at decode, for timeout capture
  logic [NUM_SLAVES-1:0] match, port_act;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  hit, req, rsp, expire, to_err;
  logic                  s_ack, s_err, s_rty;

  assign req = wbm_cyc_i & wbm_stb_i;

  // Per-slave decode/gating plus unconditional broadcast of pass-through buses.
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_port
    assign port_act[g] = (state == S_ACTIVE) && (sel_idx == IW'(g));

    wb_mux_n_port #(.AW(ADDR_WIDTH)) u_port (
      .adr   (wbm_adr_i),
      .base  (wbs_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .msk   (wbs_addr_msk[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .act   (port_act[g]),
      .cyc   (wbm_cyc_i),
      .stb   (wbm_stb_i),
      .we    (wbm_we_i),
      .match (match[g]),
      .cyc_o (wbs_cyc_o[g]),
      .stb_o (wbs_stb_o[g]),
      .we_o  (wbs_we_o[g])
    );

    assign wbs_adr_o[g*ADDR_WIDTH +: ADDR_WIDTH]     = wbm_adr_i;
    assign wbs_dat_o[g*DATA_WIDTH +: DATA_WIDTH]     = wbm_dat_i;
    assign wbs_sel_o[g*SELECT_WIDTH +: SELECT_WIDTH] = wbm_sel_i;
  end

  // Lowest matching index wins: scan downwards so the last write is the lowest.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Response path: only the owning slave is visible; port_act is all-zero
  // outside ACTIVE, which also forces read data to zero there.
  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (port_act[i]) rd_dat = wbs_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign s_ack  = |(wbs_ack_i & port_act);
  assign s_err  = |(wbs_err_i & port_act);
  assign s_rty  = |(wbs_rty_i & port_act);
  assign rsp    = s_ack | s_err | s_rty;
  assign expire = (TIMEOUT != 0) && (cnt == TO_LAST);

  assign wbm_dat_o = rd_dat;
  assign wbm_ack_o = s_ack;
  assign wbm_rty_o = s_rty;
  assign wbm_err_o = s_err | (state == S_ERR);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (req) state_nx = hit ? S_ACTIVE : S_ERR;
      // A response in the expiry cycle takes priority over the timeout.
      S_ACTIVE: if (!wbm_cyc_i || rsp) state_nx = S_IDLE;
                else if (expire)       state_nx = S_ERR;
      default:  state_nx = S_IDLE;
    endcase
  end

  // ERR always returns to IDLE, so this flags entry only.
  assign to_err = (state_nx == S_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sel_idx <= '0;
      cnt     <= '0;
      dec_adr <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && req) begin
        sel_idx <= hit_idx;
        dec_adr <= wbm_adr_i;
        cnt     <= '0;
      end else if (state == S_ACTIVE) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Sticky capture: first error only; a capture coinciding with a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_o   <= 1'b0;
      err_addr_o    <= '0;
      err_timeout_o <= 1'b0;
    end else if (to_err && (!err_valid_o || err_clr_i)) begin
      err_valid_o   <= 1'b1;
      err_addr_o    <= (state == S_IDLE) ? wbm_adr_i : dec_adr;
      err_timeout_o <= (state == S_ACTIVE);
    end else if (err_clr_i) begin
      err_valid_o <= 1'b0;
    end
  end
endmodule
